// File: rtl/bist_pkg.sv
// Shared constants and types for the BIST response checker and its failure log.
// The failure log exists only when BIST_FAIL_LOG_EN is defined.
package bist_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W_DEF  = 16;

  localparam int LOG_ADDR_W_DEF = 8;
  localparam int LOG_DATA_W_DEF = 8;

  // One failure log record at the default address/data widths.
  typedef struct packed {
    logic [LOG_ADDR_W_DEF-1:0] addr;
    logic [LOG_DATA_W_DEF-1:0] exp;
    logic [LOG_DATA_W_DEF-1:0] got;
  } log_entry_t;

endpackage

// File: rtl/bist_fail_fifo.sv
// Small synchronous FIFO for failure records, with a synchronous clear.
// It is instantiated by bist_resp_checker only when BIST_FAIL_LOG_EN is defined.
module bist_fail_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/bist_resp_checker.sv
// Aligns BIST read strobes with delayed memory data, flags mismatches, counts them,
// and optionally logs failing entries (BIST_FAIL_LOG_EN).
module bist_resp_checker
  import bist_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 1,
  parameter int LOG_DEPTH = 4,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           read,
  input  logic                           data,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [DATA_W-1:0]              mem_q,
  output logic                           is_equal,
  output logic [CNT_W-1:0]               fail_cnt,
  output logic                           log_valid,
  input  logic                           log_ready,
  output logic [ADDR_W-1:0]              log_addr,
  output logic [DATA_W-1:0]              log_exp,
  output logic [DATA_W-1:0]              log_got,
  output logic [$clog2(LOG_DEPTH+1)-1:0] log_cnt,
  output logic                           log_ovf
);

  // Out-of-range latencies are clamped to the supported window.
  localparam int LAT  = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                        (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam int TAIL = LAT - 1;

  logic [LAT-1:0]    vld_q, vld_d;
  logic [LAT-1:0]    exp_q, exp_d;
  logic [ADDR_W-1:0] addr_q [LAT];
  logic [ADDR_W-1:0] addr_d [LAT];
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [DATA_W-1:0] exp_word;
  logic              mismatch;
  logic              count_ev;

  always_comb begin
    vld_d     = vld_q;
    exp_d     = exp_q;
    addr_d    = addr_q;
    vld_d[0]  = read;
    exp_d[0]  = data;
    addr_d[0] = addr;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      exp_d[i]  = exp_q[i-1];
      addr_d[i] = addr_q[i-1];
    end
    if (start) vld_d = '0;
  end

  assign exp_word = {DATA_W{exp_q[TAIL]}};
  assign mismatch = vld_q[TAIL] && (mem_q != exp_word);
  assign is_equal = ~mismatch;
  // A compare coinciding with start is still visible on is_equal but not recorded.
  assign count_ev = mismatch && !start;

  always_comb begin
    fail_cnt_d = fail_cnt_q;
    if (start) begin
      fail_cnt_d = '0;
    end else if (count_ev && !(&fail_cnt_q)) begin
      fail_cnt_d = fail_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q      <= '0;
      exp_q      <= '0;
      for (int i = 0; i < LAT; i++) addr_q[i] <= '0;
      fail_cnt_q <= '0;
    end else begin
      vld_q      <= vld_d;
      exp_q      <= exp_d;
      addr_q     <= addr_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign fail_cnt = fail_cnt_q;

`ifdef BIST_FAIL_LOG_EN
  localparam int ENTRY_W = ADDR_W + 2 * DATA_W;

  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ENTRY_W-1:0] fifo_dout;
  logic               log_ovf_q, log_ovf_d;

  assign fifo_pop  = !fifo_empty && log_ready;
  assign fifo_push = count_ev && (!fifo_full || fifo_pop);

  always_comb begin
    log_ovf_d = log_ovf_q;
    if (start) begin
      log_ovf_d = 1'b0;
    end else if (count_ev && fifo_full && !fifo_pop) begin
      log_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) log_ovf_q <= 1'b0;
    else      log_ovf_q <= log_ovf_d;
  end

  bist_fail_fifo #(
    .W     (ENTRY_W),
    .DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({addr_q[TAIL], exp_word, mem_q}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (log_cnt)
  );

  assign log_valid                    = !fifo_empty;
  assign {log_addr, log_exp, log_got} = fifo_dout;
  assign log_ovf                      = log_ovf_q;
`else
  logic log_unused;

  assign log_unused = ^{log_ready, addr_q[TAIL]};
  assign log_valid  = 1'b0;
  assign log_addr   = '0;
  assign log_exp    = '0;
  assign log_got    = '0;
  assign log_cnt    = '0;
  assign log_ovf    = 1'b0;
`endif

endmodule

// File: doc/bist_resp_checker.md
# bist_resp_checker

Read-response checker sitting directly downstream of the BIST march controller and the memory under test. It aligns each controller read strobe, background bit and address with the memory's delayed read data, and returns the per-cycle `is_equal` result the controller samples for its sticky fail flag. It also keeps a saturating mismatch count and a small FIFO of failing address/expected/actual entries that test logic drains through a valid/ready port.

## Interface
- `ADDR_W`, 8, address width; matches the address counter.
- `DATA_W`, 8, memory word width; expected word is `{DATA_W{data}}`.
- `RD_LAT`, 1, memory read latency in cycles; legal range 1..4.
- `LOG_DEPTH`, 4, failure log entries; power of 2, at least 2.
- `CNT_W`, 16, mismatch counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  test start pulse, the same pulse given to the controller; clears the checker.
- `read`  in  1  controller read strobe.
- `data`  in  1  controller background bit.
- `addr`  in  ADDR_W  current address counter value.
- `mem_q`  in  DATA_W  memory read data, valid `RD_LAT` cycles after `read`.
- `is_equal`  out  1  0 only in a cycle where an aligned compare mismatches.
- `fail_cnt`  out  CNT_W  saturating mismatch count.
- `log_valid`  out  1  log head entry available.
- `log_ready`  in  1  consumer accepts the head entry.
- `log_addr`  out  ADDR_W  head entry address.
- `log_exp`  out  DATA_W  head entry expected word.
- `log_got`  out  DATA_W  head entry actual word.
- `log_cnt`  out  $clog2(LOG_DEPTH+1)  number of entries held.
- `log_ovf`  out  1  sticky; a mismatch was dropped because the log was full.

## Operation
- Alignment pipeline: `RD_LAT` register stages, each holding {valid, exp_bit, addr}. Stage 0 loads {`read`, `data`, `addr`} every cycle.
- The tail stage is the compare slot. `mismatch = tail.valid && (mem_q != {DATA_W{tail.exp_bit}})`.
- `is_equal = ~mismatch`, combinational from the tail stage and `mem_q`. It is 1 whenever no compare is pending.
- On `mismatch`:
  - `fail_cnt` increments and holds at all-ones.
  - If the log is not full, push {tail.addr, expected word, `mem_q`}.
  - If the log is full and no pop happens that cycle, drop the entry and set `log_ovf`.
- Log FIFO is first-in first-out. A pop occurs when `log_valid && log_ready`. The `log_*` data outputs show the head entry and are 0 when the log is empty.
- Push and pop in the same cycle while full: both take effect, `log_cnt` is unchanged, and `log_ovf` is not set.
- `start` high for one edge clears the pipeline valid bits, the FIFO, `fail_cnt` and `log_ovf`. A tail compare in the same cycle as `start` is discarded: it does not count or log, but `is_equal` still reflects it combinationally.
- Reset values: pipeline invalid, `is_equal`=1, `fail_cnt`=0, `log_valid`=0, `log_cnt`=0, `log_ovf`=0, `log_addr`/`log_exp`/`log_got`=0.
- Reset asserted mid-test clears everything immediately, independent of `clk`.

## Timing
- `read` sampled at edge t. Its compare falls in cycle t+RD_LAT, where `is_equal` is valid for the controller's edge at the end of that cycle.
- `fail_cnt`, `log_cnt` and `log_valid` update at that same edge, i.e. they are visible from cycle t+RD_LAT+1.
- Back-to-back reads give one compare per cycle, with no bubbles.
- A pop takes effect at the edge where `log_valid && log_ready`. The next entry appears the following cycle.

## Configuration
- `BIST_FAIL_LOG_EN` defined: the FIFO, the readout port and `log_ovf` are implemented as described.
- `BIST_FAIL_LOG_EN` undefined:
  - No FIFO storage.
  - `log_valid`, `log_cnt`, `log_ovf` and all `log_*` data outputs are tied to 0; `log_ready` is ignored.
  - `is_equal` and `fail_cnt` behave identically to the defined case.
  - The port list is unchanged.

## Structure
- Shared package `bist_pkg` holds:
  - the log entry typedef {addr, exp, got};
  - the `RD_LAT` legal-range constants;
  - the saturating counter width default.
- One sub-module, `bist_fail_fifo`: a parameterised synchronous FIFO with push, pop, full, empty and count, instantiated only under `BIST_FAIL_LOG_EN`.

## Test plan
- **Match:** RD_LAT=1; `read`=1, `addr`=0x05, `data`=1; next cycle `mem_q`=0xFF → `is_equal` stays 1, `fail_cnt`=0, `log_valid`=0.
- **Single mismatch:** RD_LAT=1; `read`=1, `addr`=0x12, `data`=0; next cycle `mem_q`=0x04 → `is_equal`=0 for exactly that cycle; one cycle later `fail_cnt`=1, `log_valid`=1, head entry {0x12, 0x00, 0x04}.
- **Overflow:** LOG_DEPTH=4, `log_ready`=0, six consecutive mismatching reads at 0x00..0x05 → `log_cnt`=4, `log_ovf`=1, `fail_cnt`=6; then drain with `log_ready`=1 → entries 0x00..0x03 returned in order.
- **Full with simultaneous push and pop:** log full, pop and mismatch at 0x20 in the same cycle → `log_cnt` stays 4, 0x20 is the tail entry, `log_ovf` stays 0.
- **Start while pending:** RD_LAT=3, `read` issued, `start` pulsed two cycles later → that compare is not counted or logged; `fail_cnt`=0, `log_cnt`=0.
- **Async reset and saturation:** `rst` driven low mid-run → all outputs at reset values before the next edge. With CNT_W=4, 20 mismatches → `fail_cnt`=15.
